led_flow_ctrl: RTL and testbench

- Consumes the slow square-wave clock from the LED-flow divider stage and advances an LED pattern by one position per divider period.
- Synchronises the divider output into the `clkin` domain and detects its rising edge; each detected edge is one "step".
- Four selectable flow modes: rotate left, rotate right, ping-pong, fill/drain. Supports pause and direct pattern load. Drives the board LEDs directly.

---
 rtl/led_flow_ctrl.sv | 116 +++++++++++
 tb/tb_led_flow_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_flow_ctrl.sv
// LED flow controller: synchronises the divider's slow clock, turns each rising
// edge into one step and advances the LED pattern in one of four flow modes.
module led_flow_ctrl #(
    parameter int LED_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             step_in,
    input  logic [1:0]       mode,
    input  logic             pause,
    input  logic             load,
    input  logic [LED_W-1:0] pattern_in,
    output logic [LED_W-1:0] led,
    output logic             dir_out,
    output logic             step_pulse
);

    typedef enum logic [1:0] {
        ROT_L      = 2'b00,
        ROT_R      = 2'b01,
        PING_PONG  = 2'b10,
        FILL_DRAIN = 2'b11
    } flow_mode_t;

    localparam logic [LED_W-1:0] LSB_ONLY = LED_W'(1);
    localparam logic [LED_W-1:0] MSB_ONLY = {1'b1, {(LED_W-1){1'b0}}};

    flow_mode_t             mode_q;
    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   s_prev;
    logic [LED_W-1:0]       adv_led;
    logic                   adv_dir;

    // Pattern each mode restarts from when selected without a load.
    function automatic logic [LED_W-1:0] seed_of(input flow_mode_t m);
        case (m)
            ROT_R:      return MSB_ONLY;
            FILL_DRAIN: return '0;
            default:    return LSB_ONLY;
        endcase
    endfunction

    // sync_pipe[0] is the metastability-exposed flop; only the last stage is used.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            sync_pipe <= '0;
            s_prev    <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], step_in};
            s_prev    <= sync_pipe[SYNC_STAGES-1];
        end
    end

    assign step_pulse = sync_pipe[SYNC_STAGES-1] & ~s_prev;

    always_comb begin
        adv_led = led;
        adv_dir = dir_out;
        case (mode_q)
            ROT_L: adv_led = {led[LED_W-2:0], led[LED_W-1]};
            ROT_R: adv_led = {led[0], led[LED_W-1:1]};
            PING_PONG: begin
                // Bounce at the ends; the turn-around step already moves away.
                if (!dir_out && led[LED_W-1]) begin
                    adv_dir = 1'b1;
                    adv_led = led >> 1;
                end else if (dir_out && led[0]) begin
                    adv_dir = 1'b0;
                    adv_led = led << 1;
                end else begin
                    adv_led = dir_out ? (led >> 1) : (led << 1);
                end
            end
            FILL_DRAIN: begin
                if (!dir_out) begin
                    if (&led) begin
                        adv_dir = 1'b1;
                        adv_led = {led[LED_W-2:0], 1'b0};
                    end else begin
                        adv_led = {led[LED_W-2:0], 1'b1};
                    end
                end else begin
                    if (led == '0) begin
                        adv_dir = 1'b0;
                        adv_led = LSB_ONLY;
                    end else begin
                        adv_led = {led[LED_W-2:0], 1'b0};
                    end
                end
            end
            default: ;
        endcase
    end

    // Load and mode change both swallow a coincident step; pause drops it.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            led     <= LSB_ONLY;
            dir_out <= 1'b0;
            mode_q  <= ROT_L;
        end else if (load) begin
            led     <= pattern_in;
            dir_out <= 1'b0;
            mode_q  <= flow_mode_t'(mode);
        end else if (flow_mode_t'(mode) != mode_q) begin
            led     <= seed_of(flow_mode_t'(mode));
            dir_out <= 1'b0;
            mode_q  <= flow_mode_t'(mode);
        end else if (step_pulse && !pause) begin
            led     <= adv_led;
            dir_out <= adv_dir;
        end
    end

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Bench for led_flow_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against an event-level model.
module tb_led_flow_ctrl;

    logic       clkin = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_in = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       pause = 1'b0;
    logic       load = 1'b0;
    logic [7:0] pattern_in = 8'h00;
    logic [7:0] led;
    logic       dir_out;
    logic       step_pulse;

    int checks = 0;
    int errors = 0;
    int sp_count = 0;
    bit chk_en = 0;

    led_flow_ctrl #(.LED_W(8), .SYNC_STAGES(2)) dut (
        .clkin(clkin), .rst_n(rst_n), .step_in(step_in), .mode(mode),
        .pause(pause), .load(load), .pattern_in(pattern_in),
        .led(led), .dir_out(dir_out), .step_pulse(step_pulse)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: each sampled rising edge of step_in becomes a step that
    // is applied two edges later; the pattern evolves by integer arithmetic.
    int       edge_n = 0;
    int       apply_q[$];
    bit       prev_s = 0;
    int       m_led = 1;
    bit       m_dir = 0;
    int       m_mode = 0;

    function automatic int seed(input int md);
        case (md)
            1:       return 128;
            3:       return 0;
            default: return 1;
        endcase
    endfunction

    always @(posedge clkin) begin
        bit stp;
        edge_n++;
        if (!rst_n) begin
            m_led = 1; m_dir = 0; m_mode = 0; prev_s = 0;
            apply_q.delete();
        end else begin
            stp = (apply_q.size() > 0 && apply_q[0] == edge_n);
            if (stp) void'(apply_q.pop_front());
            if (step_in && !prev_s) apply_q.push_back(edge_n + 2);
            prev_s = step_in;
            if (load) begin
                m_led = int'(pattern_in); m_dir = 0; m_mode = int'(mode);
            end else if (int'(mode) != m_mode) begin
                m_mode = int'(mode); m_dir = 0; m_led = seed(m_mode);
            end else if (stp && !pause) begin
                case (m_mode)
                    0: m_led = ((m_led * 2) % 256) + (m_led / 128);
                    1: m_led = (m_led / 2) + (m_led % 2) * 128;
                    2: begin
                        if (!m_dir && m_led >= 128) begin m_dir = 1; m_led = m_led / 2; end
                        else if (m_dir && (m_led % 2) == 1) begin m_dir = 0; m_led = (m_led * 2) % 256; end
                        else m_led = m_dir ? m_led / 2 : (m_led * 2) % 256;
                    end
                    default: begin
                        if (!m_dir) begin
                            if (m_led == 255) begin m_dir = 1; m_led = 254; end
                            else m_led = (m_led * 2 + 1) % 256;
                        end else begin
                            if (m_led == 0) begin m_dir = 0; m_led = 1; end
                            else m_led = (m_led * 2) % 256;
                        end
                    end
                endcase
            end
        end
        if (step_pulse === 1'b1) sp_count++;
    end

    always @(negedge clkin) begin
        if (chk_en) begin
            chk("model_led", 32'(led), 32'(m_led));
            chk("model_dir", 32'(dir_out), 32'(m_dir));
            chk("model_step_pulse", 32'(step_pulse),
                32'(apply_q.size() > 0 && apply_q[0] == edge_n + 1));
        end
    end

    task automatic tick();
        @(negedge clkin);
    endtask

    task automatic pulse(input int hi, input int lo);
        step_in = 1'b1;
        repeat (hi) tick();
        step_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    logic [7:0] pp_exp [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    logic       pp_dir [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [7:0] fd_exp [17] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE,
                                8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};

    initial begin
        int sp0;
        // 1: reset state and rotate-left latency
        tick();
        chk_en = 1;
        tick();
        chk("reset_led", 32'(led), 32'h01);
        chk("reset_dir", 32'(dir_out), 32'h0);
        chk("reset_sp", 32'(step_pulse), 32'h0);
        rst_n = 1'b1;
        tick();
        step_in = 1'b1;
        tick();
        chk("lat_e1_sp", 32'(step_pulse), 32'h0);
        tick();
        chk("lat_e2_sp", 32'(step_pulse), 32'h1);
        chk("lat_e2_led", 32'(led), 32'h01);
        tick();
        chk("lat_e3_sp", 32'(step_pulse), 32'h0);
        chk("lat_e3_led", 32'(led), 32'h02);
        repeat (7) tick();
        step_in = 1'b0;
        repeat (10) tick();
        pulse(10, 10);
        chk("rotl_2", 32'(led), 32'h04);
        pulse(10, 10);
        chk("rotl_3", 32'(led), 32'h08);

        // 2: ping-pong from reset
        mode = 2'b10;
        do_reset();
        tick();
        for (int i = 0; i < 16; i++) begin
            pulse(10, 10);
            chk($sformatf("pp_led_%0d", i), 32'(led), 32'(pp_exp[i]));
            chk($sformatf("pp_dir_%0d", i), 32'(dir_out), 32'(pp_dir[i]));
        end

        // 3: switch to fill/drain from 0x08
        mode = 2'b00;
        do_reset();
        tick();
        repeat (3) pulse(10, 10);
        chk("fd_pre", 32'(led), 32'h08);
        mode = 2'b11;
        tick();
        chk("fd_seed_led", 32'(led), 32'h00);
        chk("fd_seed_dir", 32'(dir_out), 32'h0);
        for (int i = 0; i < 17; i++) begin
            pulse(6, 6);
            chk($sformatf("fd_led_%0d", i), 32'(led), 32'(fd_exp[i]));
        end

        // 4: rotate-right wrap and pause
        mode = 2'b01; load = 1'b1; pattern_in = 8'h01;
        tick();
        load = 1'b0;
        pulse(10, 10);
        chk("rotr_wrap", 32'(led), 32'h80);
        pause = 1'b1;
        sp0 = sp_count;
        pulse(10, 10);
        pulse(10, 10);
        chk("pause_led", 32'(led), 32'h80);
        chk("pause_sp", 32'(sp_count - sp0), 32'd2);
        pause = 1'b0;
        pulse(10, 10);
        chk("unpause_led", 32'(led), 32'h40);

        // 5: load beats a coincident step
        step_in = 1'b1;
        tick();
        tick();
        chk("load_sp", 32'(step_pulse), 32'h1);
        load = 1'b1; pattern_in = 8'hA5; mode = 2'b00;
        tick();
        load = 1'b0;
        chk("load_led", 32'(led), 32'hA5);
        repeat (7) tick();
        step_in = 1'b0;
        repeat (10) tick();
        chk("load_discard", 32'(led), 32'hA5);
        pulse(10, 10);
        chk("load_rotl", 32'(led), 32'h4B);

        // 6: long level gives one step; reset drops an in-flight step
        sp0 = sp_count;
        pulse(100, 10);
        chk("long_sp", 32'(sp_count - sp0), 32'd1);
        chk("long_led", 32'(led), 32'h96);
        sp0 = sp_count;
        step_in = 1'b1;
        tick();
        tick();
        chk("rst_sp", 32'(step_pulse), 32'h1);
        rst_n = 1'b0;
        step_in = 1'b0;
        tick();
        chk("midrst_led", 32'(led), 32'h01);
        chk("midrst_dir", 32'(dir_out), 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("midrst_hold", 32'(led), 32'h01);
        chk("midrst_nostep", 32'(sp_count - sp0), 32'd1);

        // Randomized phase, checked by the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) step_in = ~step_in;
            pause      = ($urandom_range(0, 4) == 0);
            load       = ($urandom_range(0, 23) == 0);
            pattern_in = 8'($urandom);
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom);
            rst_n      = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1'b1; load = 1'b0; pause = 1'b0; step_in = 1'b0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
